// File: rtl/sa_iport_rr_lock.sv
// Input-port stage of a separable switch allocator: round-robin pick among V VCs,
// forwards the winner's request, returns the grant, and can hold the port for a whole packet.
module sa_iport_rr_lock #(
   parameter int N       = 5,
   parameter int V       = 4,
   parameter bit LOCK_EN = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [V*N-1:0] reqSA_in,
   input  logic [V-1:0]   vcTail_in,
   input  logic           inputGrantSAIn,
   output logic [N-1:0]   reqSAOut,
   output logic [V-1:0]   inputGrantSA_to_VC,
   output logic [V-1:0]   inputVCSelect,
   output logic           locked
);

   localparam int PW = $clog2(V);

   typedef enum logic [0:0] {IDLE = 1'b0, LOCKED = 1'b1} lock_st_t;

   lock_st_t        lock_st;
   logic [PW-1:0]   ptr;
   logic [PW-1:0]   lock_vc;
   logic [V-1:0]    vc_vld;
   logic [PW-1:0]   win;
   logic            sel_vld;
   logic            gnt;
   int              idx;

   for (genvar v = 0; v < V; v++) begin : g_vld
      assign vc_vld[v] = |reqSA_in[v*N +: N];
   end

   always_comb begin
      win     = '0;
      sel_vld = 1'b0;
      idx     = 0;
      if (lock_st == LOCKED) begin
         // A locked port keeps selecting its VC even if that VC has no request this cycle.
         win     = lock_vc;
         sel_vld = 1'b1;
      end else begin
         for (int k = 0; k < V; k++) begin
            idx = (int'(ptr) + k) % V;
            if (!sel_vld && vc_vld[idx]) begin
               sel_vld = 1'b1;
               win     = PW'(idx);
            end
         end
      end
   end

   assign gnt                = sel_vld && inputGrantSAIn && !rst;
   assign inputVCSelect      = (sel_vld && !rst) ? ({{(V-1){1'b0}}, 1'b1} << win) : '0;
   assign reqSAOut           = (sel_vld && !rst) ? reqSA_in[int'(win)*N +: N] : '0;
   assign inputGrantSA_to_VC = inputGrantSAIn ? inputVCSelect : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr     <= '0;
         lock_st <= IDLE;
         lock_vc <= '0;
         locked  <= 1'b0;
      end else if (gnt) begin
         if (LOCK_EN && !vcTail_in[win]) begin
            lock_st <= LOCKED;
            lock_vc <= win;
            locked  <= 1'b1;
         end else begin
            // Winner drops to lowest priority once its packet (or flit) is done.
            lock_st <= IDLE;
            locked  <= 1'b0;
            if (win == PW'(V-1))
               ptr <= '0;
            else
               ptr <= win + PW'(1);
         end
      end
   end

endmodule

// File: tb/tb_sa_iport_rr_lock.sv
// Directed bench for sa_iport_rr_lock: one locking and one non-locking instance.
module tb_sa_iport_rr_lock;
   localparam int N = 5;
   localparam int V = 4;

   typedef struct {
      string          tag;
      int             who;
      logic [V-1:0]   sel;
      logic [N-1:0]   req;
      logic [V-1:0]   gnt;
      logic           lk;
   } exp_t;

   logic           clk = 1'b0;
   logic           rst1 = 1'b1;
   logic           rst0 = 1'b1;
   logic [V*N-1:0] req = '0;
   logic [V-1:0]   tail = '1;
   logic           g = 1'b0;

   logic [N-1:0] req_o1, req_o0;
   logic [V-1:0] gnt_o1, gnt_o0, sel_o1, sel_o0;
   logic         lk_o1, lk_o0;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sa_iport_rr_lock #(.N(N), .V(V), .LOCK_EN(1'b1)) dut1 (
      .clk(clk), .rst(rst1), .reqSA_in(req), .vcTail_in(tail), .inputGrantSAIn(g),
      .reqSAOut(req_o1), .inputGrantSA_to_VC(gnt_o1), .inputVCSelect(sel_o1), .locked(lk_o1));

   sa_iport_rr_lock #(.N(N), .V(V), .LOCK_EN(1'b0)) dut0 (
      .clk(clk), .rst(rst0), .reqSA_in(req), .vcTail_in(tail), .inputGrantSAIn(g),
      .reqSAOut(req_o0), .inputGrantSA_to_VC(gnt_o0), .inputVCSelect(sel_o0), .locked(lk_o0));

   function automatic logic [V*N-1:0] mk(input logic [N-1:0] v0, v1, v2, v3);
      return {v3, v2, v1, v0};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // who: 0 = drive only, 1 = check locking instance, 2 = check non-locking instance
   task automatic step(input string tag, input int who, input logic r1,
                       input logic [V*N-1:0] rq, input logic [V-1:0] tl, input logic gi,
                       input logic [V-1:0] e_sel, input logic [N-1:0] e_req,
                       input logic [V-1:0] e_gnt, input logic e_lk);
      exp_t e;
      @(negedge clk);
      rst1 = r1;
      req  = rq;
      tail = tl;
      g    = gi;
      if (who != 0) exp_q.push_back('{tag, who, e_sel, e_req, e_gnt, e_lk});
      #1;
      if (who != 0) begin
         e = exp_q.pop_front();
         if (e.who == 1) begin
            check({e.tag, ".sel"}, 32'(sel_o1), 32'(e.sel));
            check({e.tag, ".req"}, 32'(req_o1), 32'(e.req));
            check({e.tag, ".gnt"}, 32'(gnt_o1), 32'(e.gnt));
            check({e.tag, ".lk"},  32'(lk_o1),  32'(e.lk));
         end else begin
            check({e.tag, ".sel"}, 32'(sel_o0), 32'(e.sel));
            check({e.tag, ".req"}, 32'(req_o0), 32'(e.req));
            check({e.tag, ".gnt"}, 32'(gnt_o0), 32'(e.gnt));
            check({e.tag, ".lk"},  32'(lk_o0),  32'(e.lk));
         end
      end
   endtask

   initial begin
      logic [V*N-1:0] all4;
      logic [V*N-1:0] r;
      all4 = mk(5'b00001, 5'b00010, 5'b00100, 5'b10000);

      // outputs forced to zero while reset is held, even with requests and grant present
      step("rst_hold", 1, 1'b1, all4, 4'b1111, 1'b1, 4'b0000, 5'b0, 4'b0000, 1'b0);
      step("idle_gnt", 1, 1'b0, '0, 4'b1111, 1'b1, 4'b0000, 5'b0, 4'b0000, 1'b0);
      step("idle_gnt2", 1, 1'b0, '0, 4'b1111, 1'b1, 4'b0000, 5'b0, 4'b0000, 1'b0);

      // VC1 and VC3 alternate
      r = mk(5'b0, 5'b00100, 5'b0, 5'b01000);
      step("rr_c1", 1, 1'b0, r, 4'b1111, 1'b1, 4'b0010, 5'b00100, 4'b0010, 1'b0);
      step("rr_c2", 1, 1'b0, r, 4'b1111, 1'b1, 4'b1000, 5'b01000, 4'b1000, 1'b0);
      step("rr_c3", 1, 1'b0, r, 4'b1111, 1'b1, 4'b0010, 5'b00100, 4'b0010, 1'b0);
      // only VC3 requests: ptr 2 -> VC3 wins, ptr wraps to 0
      step("wrap_prep", 1, 1'b0, mk(5'b0, 5'b0, 5'b0, 5'b01000), 4'b1111, 1'b1,
           4'b1000, 5'b01000, 4'b1000, 1'b0);

      // all four request: 0,1,2,3,0 with a no-grant hold in the middle
      step("all_vc0", 1, 1'b0, all4, 4'b1111, 1'b1, 4'b0001, 5'b00001, 4'b0001, 1'b0);
      step("all_vc1", 1, 1'b0, all4, 4'b1111, 1'b1, 4'b0010, 5'b00010, 4'b0010, 1'b0);
      step("all_hold", 1, 1'b0, all4, 4'b1111, 1'b0, 4'b0100, 5'b00100, 4'b0000, 1'b0);
      step("all_vc2", 1, 1'b0, all4, 4'b1111, 1'b1, 4'b0100, 5'b00100, 4'b0100, 1'b0);
      step("all_vc3", 1, 1'b0, all4, 4'b1111, 1'b1, 4'b1000, 5'b10000, 4'b1000, 1'b0);
      step("all_wrap", 1, 1'b0, all4, 4'b1111, 1'b1, 4'b0001, 5'b00001, 4'b0001, 1'b0);

      // packet lock on VC2 (ptr is 1 here)
      step("lk_head", 1, 1'b0, mk(5'b0, 5'b0, 5'b00001, 5'b0), 4'b1011, 1'b1,
           4'b0100, 5'b00001, 4'b0100, 1'b0);
      step("lk_body", 1, 1'b0, mk(5'b00010, 5'b0, 5'b00001, 5'b0), 4'b1011, 1'b1,
           4'b0100, 5'b00001, 4'b0100, 1'b1);
      step("lk_empty", 1, 1'b0, mk(5'b00010, 5'b0, 5'b0, 5'b0), 4'b1011, 1'b0,
           4'b0100, 5'b0, 4'b0000, 1'b1);
      step("lk_tail", 1, 1'b0, mk(5'b00010, 5'b0, 5'b00001, 5'b0), 4'b1111, 1'b1,
           4'b0100, 5'b00001, 4'b0100, 1'b1);
      step("lk_after", 1, 1'b0, mk(5'b00010, 5'b0, 5'b0, 5'b00100), 4'b1111, 1'b0,
           4'b1000, 5'b00100, 4'b0000, 1'b0);

      // non-locking instance, same head-of-packet stimulus
      rst0 = 1'b0;
      step("nl_c1", 2, 1'b0, mk(5'b0, 5'b0, 5'b00001, 5'b0), 4'b0000, 1'b1,
           4'b0100, 5'b00001, 4'b0100, 1'b0);
      r = mk(5'b00010, 5'b0, 5'b00001, 5'b00100);
      step("nl_c2", 2, 1'b0, r, 4'b0000, 1'b1, 4'b1000, 5'b00100, 4'b1000, 1'b0);
      step("nl_c3", 2, 1'b0, r, 4'b0000, 1'b1, 4'b0001, 5'b00010, 4'b0001, 1'b0);
      step("nl_c4", 2, 1'b0, r, 4'b0000, 1'b1, 4'b0100, 5'b00001, 4'b0100, 1'b0);

      // locking instance: release whatever it holds, then lock onto VC1 and reset mid-packet
      step("rel", 0, 1'b0, mk(5'b0, 5'b0, 5'b00001, 5'b0), 4'b1111, 1'b1, '0, '0, '0, 1'b0);
      step("l1_head", 1, 1'b0, mk(5'b0, 5'b00100, 5'b0, 5'b0), 4'b0000, 1'b1,
           4'b0010, 5'b00100, 4'b0010, 1'b0);
      r = mk(5'b00001, 5'b00100, 5'b0, 5'b0);
      step("l1_held", 1, 1'b0, r, 4'b0000, 1'b0, 4'b0010, 5'b00100, 4'b0000, 1'b1);
      step("l1_rst", 1, 1'b1, r, 4'b0000, 1'b1, 4'b0000, 5'b0, 4'b0000, 1'b0);
      step("post_rst", 1, 1'b0, r, 4'b1111, 1'b0, 4'b0001, 5'b00001, 4'b0000, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sa_iport_rr_lock.md
Name: sa_iport_rr_lock

Overview:
- Parametrised input-port stage of the 2-stage separable switch allocator (input-first).
- Arbitrates locally among V VCs of one input port with a round-robin pointer and forwards the winner's N-bit output request to the main allocator.
- Demultiplexes the main allocator's input grant back to the winning VC and drives the local VC mux select.
- Adds packet-level grant locking: a VC that wins with a non-tail flit keeps the port until its tail flit is granted.

Parameters:
- N, 5, number of router output ports (request vector width per VC).
- V, 4, number of VCs on this input port; any value >= 2.
- LOCK_EN, 1, 1 = hold the local grant for the whole packet; 0 = re-arbitrate every granted flit.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- reqSA_in  input  V*N  per-VC output request; VC v occupies bits [v*N +: N]
- vcTail_in  input  V  bit v = head flit of VC v is a tail (single-flit packets set it)
- inputGrantSAIn  input  1  main allocator granted this input port this cycle
- reqSAOut  output  N  request of the selected VC, forwarded to the main allocator
- inputGrantSA_to_VC  output  V  one-hot grant to the winning VC
- inputVCSelect  output  V  one-hot local VC mux select
- locked  output  1  port is locked to a VC mid-packet

Behaviour:
- State: ptr (log2 V bits, round-robin start index), lock_st (IDLE/LOCKED), lock_vc (log2 V bits).
- Reset (async, rst=1): ptr=0, lock_st=IDLE, lock_vc=0. While rst=1 all outputs are 0 regardless of inputs.
- VC v is valid when any bit of its N-bit slice is 1. A multi-bit slice is forwarded unchanged; no one-hot check is made.
- IDLE selection: the first valid VC searching ptr, ptr+1, ... wrapping modulo V.
  - No valid VC: inputVCSelect=0, reqSAOut=0.
- LOCKED selection: always lock_vc; all other VCs are masked.
  - If lock_vc's slice is 0, inputVCSelect is still onehot(lock_vc) and reqSAOut=0.
- Timing:
  - reqSAOut, inputVCSelect and inputGrantSA_to_VC are combinational from inputs and current state, with zero-cycle latency.
  - inputGrantSA_to_VC = inputVCSelect AND inputGrantSAIn.
  - State updates on the next rising clk edge.
- inputGrantSAIn=1 while inputVCSelect=0: no grant output and no state change.
- On a granted cycle with winner w, at the clock edge:
  - LOCK_EN=1 and vcTail_in[w]=0: lock_st=LOCKED, lock_vc=w, ptr unchanged.
  - vcTail_in[w]=1, or LOCK_EN=0: lock_st=IDLE, ptr=(w+1) mod V, so the winner becomes lowest priority. Wrap: w=V-1 gives ptr=0.
- No grant: the pointer and lock do not move. Priority advances only on a grant.
- LOCK_EN=0: lock_st is constant IDLE and locked is constant 0.
- locked = (lock_st==LOCKED), registered.
- Reset asserted mid-packet: the lock is dropped immediately and ptr returns to 0.

Test Plan:
- Reset, no requests (V=4, N=5), then inputGrantSAIn=1 -> reqSAOut=0, inputVCSelect=0, inputGrantSA_to_VC=0, locked=0, ptr stays 0.
- VC1=5'b00100, VC3=5'b01000, tails all 1, grant held 1 for 3 cycles:
  - Cycle 1: inputVCSelect=0010, reqSAOut=00100, grant_to_VC=0010; ptr becomes 2.
  - Cycle 2: VC3 wins with 01000; ptr becomes 0.
  - Cycle 3: VC1 wins.
- All four VCs requesting, tails 1, grant every cycle -> grant order VC0, VC1, VC2, VC3, VC0 (wrap-around check).
- LOCK_EN=1, VC2 non-tail head granted:
  - Next cycle locked=1 and VC0 requesting is ignored; inputVCSelect=0100.
  - VC2 request drops to 0 for one cycle: reqSAOut=0, select stays 0100.
  - VC2 tail granted: locked=0, ptr=3.
- Same stimulus with LOCK_EN=0 -> VC2 granted, ptr=3, VC3/VC0 win in the following cycles, locked stays 0.
- rst pulsed while locked to VC1 -> outputs immediately 0; after release locked=0, ptr=0, and VC0 wins over VC1 when both request.
